// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Definitions shared by the ADC scan controller:
//   - FSM state encoding, kept as plain localparam constants
//   - overrange codes (+127 / -127) of the 8-bit signed flash converter
//   - width helper for channel indices, and the overrange test
// -----------------------------------------------------------------------------
package adc_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_SETTLE    = 3'd1;
   localparam state_t ST_CONVERT   = 3'd2;
   localparam state_t ST_HOLD      = 3'd3;
   localparam state_t ST_STOP_WAIT = 3'd4;

   // Codes the converter produces when its input clips.
   localparam logic [7:0] ADC_OVR_POS = 8'h7F;  // +127
   localparam logic [7:0] ADC_OVR_NEG = 8'h81;  // -127

   // Bits needed to index n channels (never less than one).
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_ovr(input logic [7:0] sample);
      return (sample == ADC_OVR_POS) || (sample == ADC_OVR_NEG);
   endfunction

endpackage

// File: rtl/adc_scan_controller_if.sv
// -----------------------------------------------------------------------------
// adc_scan_controller_if
// Result stream of the scan controller: valid/ready handshake carrying the
// channel tag, the captured sample and the overrange flag.
//   master : the controller (drives valid/data, receives ready)
//   slave  : the result consumer
// -----------------------------------------------------------------------------
interface adc_scan_controller_if #(
   parameter int CH_W = 2
);
   logic            res_valid;
   logic            res_ready;
   logic [CH_W-1:0] res_ch;
   logic [7:0]      res_data;
   logic            res_ovr;

   modport master (
      output res_valid, res_ch, res_data, res_ovr,
      input  res_ready
   );

   modport slave (
      input  res_valid, res_ch, res_data, res_ovr,
      output res_ready
   );
endinterface

// File: rtl/adc_rr_next.sv
// -----------------------------------------------------------------------------
// adc_rr_next
// Combinational round-robin finder: returns the lowest enabled channel above
// cur_i. When no enabled channel lies above cur_i, it returns the lowest
// enabled channel and raises wrap_o.
//   mask_i : per-channel enable mask
//   cur_i  : current channel index
//   nxt_o  : next enabled channel index
//   wrap_o : 1 when cur_i was at or above the highest enabled channel
// -----------------------------------------------------------------------------
module adc_rr_next
   import adc_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [CH_W-1:0]   cur_i,
   output logic [CH_W-1:0]   nxt_o,
   output logic              wrap_o
);

   always_comb begin
      // NOTE: every output gets a default before any conditional assignment,
      // so no path through the block leaves it unassigned (no latch inferred).
      nxt_o  = '0;
      wrap_o = 1'b1;
      // Descending scans: the last hit is the lowest matching index.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i]) nxt_o = CH_W'(i);
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(cur_i))) begin
            nxt_o  = CH_W'(i);
            wrap_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/adc_scan_controller.sv
// -----------------------------------------------------------------------------
// adc_scan_controller
// Scans up to NUM_CH analog channels through one 8-bit flash converter.
// For each enabled channel it selects the mux, waits SETTLE_CYC cycles,
// holds the convert strobe for CONV_CYC cycles, captures the sample and
// offers it on the result handshake. It runs one pass, or loops when
// `continuous` is set, until the pass ends or a stop request arrives.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse that begins a scan (ignored while busy)
//   continuous   : restart after the last channel (sampled at start)
//   chan_en      : per-channel enable mask (sampled at start)
//   stop         : ends the scan after the next delivered result
//   adc_data     : signed converter output
//   adc_ch_sel   : analog mux select
//   adc_conv     : high while a conversion is in progress
//   busy         : high in every state except IDLE
//   res_if       : result handshake (valid/ready, channel, data, overrange)
// -----------------------------------------------------------------------------
module adc_scan_controller
   import adc_pkg::*;
#(
   parameter  int NUM_CH     = 4,
   parameter  int SETTLE_CYC = 2,
   parameter  int CONV_CYC   = 10,
   localparam int CH_W       = ch_width(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 continuous,
   input  logic [NUM_CH-1:0]    chan_en,
   input  logic                 stop,
   input  logic [7:0]           adc_data,
   output logic [CH_W-1:0]      adc_ch_sel,
   output logic                 adc_conv,
   output logic                 busy,
   adc_scan_controller_if.master res_if
);

   // Counters load N-1 and the state moves on when they reach zero,
   // giving exactly N cycles in each timed state.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] CONV_LOAD   = 8'(CONV_CYC - 1);

   state_t              state_q,    state_d;
   logic [7:0]          cnt_q,      cnt_d;
   logic [CH_W-1:0]     ch_sel_q,   ch_sel_d;
   logic [NUM_CH-1:0]   mask_q,     mask_d;
   logic                cont_q,     cont_d;
   logic                stop_q,     stop_d;
   logic [CH_W-1:0]     res_ch_q,   res_ch_d;
   logic [7:0]          res_data_q, res_data_d;
   logic                res_ovr_q,  res_ovr_d;

   logic [NUM_CH-1:0]   rr_mask;
   logic [CH_W-1:0]     rr_cur;
   logic [CH_W-1:0]     rr_nxt;
   logic                rr_wrap;
   logic                in_idle;
   logic                handshake;
   logic                stop_pend;

   assign in_idle   = (state_q == ST_IDLE);
   assign handshake = res_if.res_valid && res_if.res_ready;
   assign stop_pend = stop_q || stop;

   // In IDLE the finder looks at the incoming mask from "above the top
   // channel", so it wraps onto the lowest enabled channel: the first one
   // of the scan. Otherwise it steps through the mask captured at start.
   assign rr_mask = in_idle ? chan_en : mask_q;
   assign rr_cur  = in_idle ? CH_W'(NUM_CH - 1) : ch_sel_q;

   adc_rr_next #(
      .NUM_CH (NUM_CH)
   ) u_rr_next (
      .mask_i (rr_mask),
      .cur_i  (rr_cur),
      .nxt_o  (rr_nxt),
      .wrap_o (rr_wrap)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ch_sel_d   = ch_sel_q;
      mask_d     = mask_q;
      cont_d     = cont_q;
      res_ch_d   = res_ch_q;
      res_data_d = res_data_q;
      res_ovr_d  = res_ovr_q;

      case (state_q)
         ST_IDLE: begin
            if (start && (|chan_en)) begin
               state_d  = ST_SETTLE;
               mask_d   = chan_en;
               cont_d   = continuous;
               ch_sel_d = rr_nxt;
               cnt_d    = SETTLE_LOAD;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_CONVERT;
               cnt_d   = CONV_LOAD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_CONVERT: begin
            if (cnt_q == 8'd0) begin
               res_data_d = adc_data;
               res_ch_d   = ch_sel_q;
               res_ovr_d  = is_ovr(adc_data);
               state_d    = stop_pend ? ST_STOP_WAIT : ST_HOLD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (handshake) begin
               if (stop_pend || (rr_wrap && !cont_q)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d  = ST_SETTLE;
                  ch_sel_d = rr_nxt;
                  cnt_d    = SETTLE_LOAD;
               end
            end else if (stop) begin
               state_d = ST_STOP_WAIT;
            end
         end
         ST_STOP_WAIT: begin
            if (handshake) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Stop requests are remembered only while busy and forgotten on the
      // way back to IDLE.
      stop_d = (stop_q || (stop && !in_idle)) && (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here is a plain flop with a reset value (there
      // is no memory array), so all of them clear on rst_n.
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ch_sel_q   <= '0;
         mask_q     <= '0;
         cont_q     <= 1'b0;
         stop_q     <= 1'b0;
         res_ch_q   <= '0;
         res_data_q <= '0;
         res_ovr_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge values, independent of statement order.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ch_sel_q   <= ch_sel_d;
         mask_q     <= mask_d;
         cont_q     <= cont_d;
         stop_q     <= stop_d;
         res_ch_q   <= res_ch_d;
         res_data_q <= res_data_d;
         res_ovr_q  <= res_ovr_d;
      end
   end

   assign adc_ch_sel       = ch_sel_q;
   assign adc_conv         = (state_q == ST_CONVERT);
   assign busy             = !in_idle;
   assign res_if.res_valid = (state_q == ST_HOLD) || (state_q == ST_STOP_WAIT);
   assign res_if.res_ch    = res_ch_q;
   assign res_if.res_data  = res_data_q;
   assign res_if.res_ovr   = res_ovr_q;

endmodule

// File: tb/tb_adc_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_controller
// Directed bench for adc_scan_controller (NUM_CH=4, SETTLE_CYC=2,
// CONV_CYC=10). A per-channel value table models the analog inputs. Expected
// results are queued when a scan is launched, and a monitor compares every
// transferred result against the head of the queue.
// -----------------------------------------------------------------------------
module tb_adc_scan_controller;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef struct {
      logic [CH_W-1:0] ch;
      logic [7:0]      data;
      logic            ovr;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              continuous;
   logic [NUM_CH-1:0] chan_en;
   logic              stop;
   logic [7:0]        adc_data;
   logic [CH_W-1:0]   adc_ch_sel;
   logic              adc_conv;
   logic              busy;

   logic [7:0]        chan_val [NUM_CH];
   exp_t              sb_q [$];
   int                n_checks  = 0;
   int                n_errors  = 0;
   int                n_results = 0;

   adc_scan_controller_if #(.CH_W(CH_W)) res_if ();

   adc_scan_controller #(
      .NUM_CH     (NUM_CH),
      .SETTLE_CYC (2),
      .CONV_CYC   (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .continuous (continuous),
      .chan_en    (chan_en),
      .stop       (stop),
      .adc_data   (adc_data),
      .adc_ch_sel (adc_ch_sel),
      .adc_conv   (adc_conv),
      .busy       (busy),
      .res_if     (res_if)
   );

   always #5 clk = ~clk;

   // Analog source: the converter sees the value of the selected channel.
   assign adc_data = chan_val[adc_ch_sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_res(input logic [CH_W-1:0] ch, input logic [7:0] data, input logic ovr);
      exp_t e;
      e.ch   = ch;
      e.data = data;
      e.ovr  = ovr;
      sb_q.push_back(e);
   endtask

   // Monitor: a transfer happens on the posedge following a negedge where
   // both valid and ready are high.
   always @(negedge clk) begin
      if (rst_n && res_if.res_valid && res_if.res_ready) begin
         n_results++;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got ch %0d data 0x%0h, expected no result",
                     res_if.res_ch, res_if.res_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("res_ch",   32'(res_if.res_ch),   32'(e.ch));
            check("res_data", 32'(res_if.res_data), 32'(e.data));
            check("res_ovr",  32'(res_if.res_ovr),  32'(e.ovr));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [NUM_CH-1:0] mask, input logic cont);
      chan_en    = mask;
      continuous = cont;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!res_if.res_valid && n < 200) begin
         tick();
         n++;
      end
      check(name, 32'(res_if.res_valid), 32'd1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int conv_cnt;
      int base;
      int n;
      logic stable;

      chan_val[0] = 8'h0A;
      chan_val[1] = 8'h14;
      chan_val[2] = 8'h81;
      chan_val[3] = 8'h7F;
      rst_n      = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      chan_en    = '0;
      stop       = 1'b0;
      res_if.res_ready = 1'b1;

      // Reset values
      repeat (3) tick();
      check("rst_ch_sel",   32'(adc_ch_sel),       32'd0);
      check("rst_conv",     32'(adc_conv),         32'd0);
      check("rst_valid",    32'(res_if.res_valid), 32'd0);
      check("rst_res_data", 32'(res_if.res_data),  32'd0);
      check("rst_res_ch",   32'(res_if.res_ch),    32'd0);
      check("rst_res_ovr",  32'(res_if.res_ovr),   32'd0);
      check("rst_busy",     32'(busy),             32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Single pass over mask 1011: ch0, ch1, ch3 (+127 -> overrange)
      expect_res(2'd0, 8'h0A, 1'b0);
      expect_res(2'd1, 8'h14, 1'b0);
      expect_res(2'd3, 8'h7F, 1'b1);
      launch(4'b1011, 1'b0);
      cyc      = 1;
      conv_cnt = 0;
      while (!res_if.res_valid && cyc < 100) begin
         if (adc_conv) conv_cnt++;
         tick();
         cyc++;
      end
      check("start_to_valid_latency", 32'(cyc), 32'd13);
      check("conv_cycles", 32'(conv_cnt), 32'd10);
      // A start while busy must not alter the running scan.
      launch(4'b0100, 1'b1);
      wait_idle("pass_1011_idle");
      check("pass_1011_all_results", 32'(sb_q.size()), 32'd0);

      // Overrange on -127, then an ordinary value on the same channel
      expect_res(2'd2, 8'h81, 1'b1);
      launch(4'b0100, 1'b0);
      wait_idle("ovr_neg_idle");
      chan_val[2] = 8'h40;
      expect_res(2'd2, 8'h40, 1'b0);
      launch(4'b0100, 1'b0);
      wait_idle("no_ovr_idle");
      check("ovr_results", 32'(sb_q.size()), 32'd0);

      // Backpressure: hold ready low for 20 cycles with a result pending
      res_if.res_ready = 1'b0;
      expect_res(2'd0, 8'h0A, 1'b0);
      expect_res(2'd1, 8'h14, 1'b0);
      launch(4'b0011, 1'b0);
      wait_valid("bp_valid");
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!res_if.res_valid || res_if.res_data != 8'h0A || res_if.res_ch != 2'd0
             || adc_conv || adc_ch_sel != 2'd0) stable = 1'b0;
         tick();
      end
      check("bp_outputs_stable", 32'(stable), 32'd1);
      check("bp_results_pending", 32'(sb_q.size()), 32'd2);
      res_if.res_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_results", 32'(sb_q.size()), 32'd0);

      // Continuous over mask 0110 (1,2,1,...); stop during ch1's second conversion
      expect_res(2'd1, 8'h14, 1'b0);
      expect_res(2'd2, 8'h40, 1'b0);
      expect_res(2'd1, 8'h14, 1'b0);
      base = n_results;
      launch(4'b0110, 1'b1);
      n = 0;
      while (n_results < base + 2 && n < 200) begin
         tick();
         n++;
      end
      n = 0;
      while (!(adc_conv && adc_ch_sel == 2'd1) && n < 50) begin
         tick();
         n++;
      end
      check("cont_in_convert_ch1", 32'(adc_conv && adc_ch_sel == 2'd1), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle("cont_stop_idle");
      check("cont_result_count", 32'(n_results - base), 32'd3);
      check("cont_results", 32'(sb_q.size()), 32'd0);

      // Stop arriving together with the handshake ends the scan
      res_if.res_ready = 1'b0;
      expect_res(2'd0, 8'h0A, 1'b0);
      launch(4'b0011, 1'b1);
      wait_valid("stop_hs_valid");
      res_if.res_ready = 1'b1;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_hs_idle", 32'(busy), 32'd0);
      repeat (20) tick();
      check("stop_hs_results", 32'(sb_q.size()), 32'd0);

      // Reset in the middle of a conversion discards the sample
      launch(4'b0001, 1'b0);
      n = 0;
      while (!adc_conv && n < 50) begin
         tick();
         n++;
      end
      check("rst_mid_in_convert", 32'(adc_conv), 32'd1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(res_if.res_valid), 32'd0);
      check("async_rst_conv",  32'(adc_conv),         32'd0);
      check("async_rst_busy",  32'(busy),             32'd0);
      check("async_rst_ch_sel", 32'(adc_ch_sel),      32'd0);
      check("async_rst_res_data", 32'(res_if.res_data), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);

      // Start with an empty mask, then stop in IDLE: both ignored
      stable = 1'b1;
      launch(4'b0000, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy || adc_conv || res_if.res_valid) stable = 1'b0;
         tick();
      end
      check("zero_mask_no_activity", 32'(stable), 32'd1);
      expect_res(2'd0, 8'h0A, 1'b0);
      launch(4'b0001, 1'b0);
      wait_idle("after_idle_stop_idle");
      check("after_idle_stop_results", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
